// File: rtl/peripheral_mpram_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one MPRAM slave among the masters of a tile.
// Define PERIPHERAL_MPRAM_ARB_TIMEOUT_EN to abort strobes the slave never acks.
module peripheral_mpram_wb_arbiter #(
    parameter int CORES_PER_TILE = 2,
    parameter int AW             = 8,
    parameter int DW             = 32,
    parameter int TIMEOUT        = 255
) (
    input  logic                                wb_clk_i,
    input  logic                                wb_rst_i,
    input  logic [CORES_PER_TILE-1:0][AW-1:0]   m_adr_i,
    input  logic [CORES_PER_TILE-1:0][DW-1:0]   m_dat_i,
    input  logic [CORES_PER_TILE-1:0][3:0]      m_sel_i,
    input  logic [CORES_PER_TILE-1:0]           m_we_i,
    input  logic [CORES_PER_TILE-1:0][1:0]      m_bte_i,
    input  logic [CORES_PER_TILE-1:0][2:0]      m_cti_i,
    input  logic [CORES_PER_TILE-1:0]           m_cyc_i,
    input  logic [CORES_PER_TILE-1:0]           m_stb_i,
    output logic [CORES_PER_TILE-1:0]           m_ack_o,
    output logic [CORES_PER_TILE-1:0]           m_err_o,
    output logic [CORES_PER_TILE-1:0][DW-1:0]   m_dat_o,
    output logic [AW-1:0]                       s_adr_o,
    output logic [DW-1:0]                       s_dat_o,
    output logic [3:0]                          s_sel_o,
    output logic                                s_we_o,
    output logic [1:0]                          s_bte_o,
    output logic [2:0]                          s_cti_o,
    output logic                                s_cyc_o,
    output logic                                s_stb_o,
    input  logic                                s_ack_i,
    input  logic                                s_err_i,
    input  logic [DW-1:0]                       s_dat_i,
    output logic [CORES_PER_TILE-1:0]           grant_o
);

    localparam int N  = CORES_PER_TILE;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    grant;
    logic [N-1:0]    grant_nxt;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   owner_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   owner_inc;
    logic [PW-1:0]   sel;
    logic            found;
    logic            busy;
    logic            release_own;
    logic            tmo_err;
    logic            stb_block;

    // Sums stay below 2*N, so one conditional subtract wraps modulo N.
    function automatic logic [PW-1:0] wrap(input logic [PW:0] v);
        logic [PW:0] r;
        r = (v >= (PW+1)'(N)) ? v - (PW+1)'(N) : v;
        return r[PW-1:0];
    endfunction

    // Scan downwards so the requester closest to the pointer wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_cyc_i[wrap({1'b0, ptr} + (PW+1)'(i))]) begin
                found = 1'b1;
                pick  = wrap({1'b0, ptr} + (PW+1)'(i));
            end
        end
    end

    assign busy        = (state == BUSY);
    assign release_own = busy & ~m_cyc_i[owner];
    assign owner_inc   = wrap({1'b0, owner} + (PW+1)'(1));

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt       = BUSY;
                    grant_nxt       = '0;
                    grant_nxt[pick] = 1'b1;
                    owner_nxt       = pick;
                end
            end
            BUSY: begin
                if (release_own) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = owner_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
        end
    end

    assign grant_o = grant;

    // When idle the slave sees master 0's request fields with cyc/stb low.
    assign sel     = busy ? owner : '0;
    assign s_adr_o = m_adr_i[sel];
    assign s_dat_o = m_dat_i[sel];
    assign s_sel_o = m_sel_i[sel];
    assign s_we_o  = m_we_i[sel];
    assign s_bte_o = m_bte_i[sel];
    assign s_cti_o = m_cti_i[sel];
    assign s_cyc_o = busy & m_cyc_i[owner];
    assign s_stb_o = busy & m_cyc_i[owner] & m_stb_i[owner] & ~stb_block;

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        if (busy) begin
            m_ack_o[owner] = s_ack_i;
            m_err_o[owner] = s_err_i | tmo_err;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            m_dat_o[i] = s_dat_i;
        end
    end

`ifdef PERIPHERAL_MPRAM_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] count;
    logic          blocked;
    logic          stall;

    assign stall     = s_stb_o & ~s_ack_i;
    assign tmo_err   = stall & (count == CW'(TIMEOUT - 1));
    assign stb_block = blocked;

    // Once timed out, strobe stays blocked until the owner ends its cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state_nxt != BUSY) begin
            count   <= '0;
            blocked <= 1'b0;
        end else begin
            if (s_ack_i) begin
                count <= '0;
            end else if (stall) begin
                count <= count + CW'(1);
            end
            if (tmo_err) begin
                blocked <= 1'b1;
            end
        end
    end
`else
    assign tmo_err   = 1'b0;
    assign stb_block = 1'b0;
`endif

endmodule

// File: tb/tb_peripheral_mpram_wb_arbiter.sv
// Directed bench for peripheral_mpram_wb_arbiter with a registered-ack memory slave.
module tb_peripheral_mpram_wb_arbiter;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0][7:0]   m_adr;
    logic [1:0][31:0]  m_dat;
    logic [1:0][3:0]   m_sel;
    logic [1:0]        m_we;
    logic [1:0][1:0]   m_bte;
    logic [1:0][2:0]   m_cti;
    logic [1:0]        m_cyc;
    logic [1:0]        m_stb;
    logic [1:0]        m_ack;
    logic [1:0]        m_err;
    logic [1:0][31:0]  m_rdat;
    logic [7:0]        s_adr;
    logic [31:0]       s_wdat;
    logic [3:0]        s_sel;
    logic              s_we;
    logic [1:0]        s_bte;
    logic [2:0]        s_cti;
    logic              s_cyc;
    logic              s_stb;
    logic              s_ack;
    logic              s_err = 1'b0;
    logic [31:0]       s_rdat;
    logic [1:0]        grant;
    logic              hang = 1'b0;
    logic [31:0]       mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    peripheral_mpram_wb_arbiter #(
        .CORES_PER_TILE(2),
        .AW(8),
        .DW(32),
        .TIMEOUT(4)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .m_adr_i(m_adr),
        .m_dat_i(m_dat),
        .m_sel_i(m_sel),
        .m_we_i(m_we),
        .m_bte_i(m_bte),
        .m_cti_i(m_cti),
        .m_cyc_i(m_cyc),
        .m_stb_i(m_stb),
        .m_ack_o(m_ack),
        .m_err_o(m_err),
        .m_dat_o(m_rdat),
        .s_adr_o(s_adr),
        .s_dat_o(s_wdat),
        .s_sel_o(s_sel),
        .s_we_o(s_we),
        .s_bte_o(s_bte),
        .s_cti_o(s_cti),
        .s_cyc_o(s_cyc),
        .s_stb_o(s_stb),
        .s_ack_i(s_ack),
        .s_err_i(s_err),
        .s_dat_i(s_rdat),
        .grant_o(grant)
    );

    // Slave: one-cycle registered ack, byte-select writes, registered read data.
    always @(posedge clk) begin
        if (rst) begin
            s_ack <= 1'b0;
        end else begin
            s_ack <= s_cyc & s_stb & ~s_ack & ~hang;
            if (s_cyc && s_stb && !s_ack && !hang) begin
                if (s_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s_sel[b]) mem[s_adr][b*8 +: 8] <= s_wdat[b*8 +: 8];
                    end
                end
                s_rdat <= mem[s_adr];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic idle_all();
        m_cyc = '0;
        m_stb = '0;
        m_we  = '0;
        m_cti = '0;
        m_bte = '0;
        m_sel = '1;
        m_adr = '0;
        m_dat = '0;
    endtask

    task automatic wait_ack(input int m, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            #1;
            if (m_ack[m]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL rst_grant got %b exp 00", grant);
        end
        checks++;
        if (s_cyc !== 1'b0) begin
            errors++; $display("FAIL rst_s_cyc got %b exp 0", s_cyc);
        end
        checks++;
        if (s_stb !== 1'b0) begin
            errors++; $display("FAIL rst_s_stb got %b exp 0", s_stb);
        end
        checks++;
        if (m_ack !== 2'b00) begin
            errors++; $display("FAIL rst_m_ack got %b exp 00", m_ack);
        end
        checks++;
        if (m_err !== 2'b00) begin
            errors++; $display("FAIL rst_m_err got %b exp 00", m_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        @(negedge clk);
        m_adr[0] = 8'h10;
        m_dat[0] = 32'hDEADBEEF;
        m_sel[0] = 4'hF;
        m_we[0]  = 1'b1;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        #1;
        checks++;
        if (s_cyc !== 1'b0) begin
            errors++; $display("FAIL single_latency0 s_cyc got %b exp 0", s_cyc);
        end
        @(negedge clk);
        #1;
        checks++;
        if (s_cyc !== 1'b1 || grant !== 2'b01) begin
            errors++; $display("FAIL single_grant s_cyc %b grant %b exp 1 01", s_cyc, grant);
        end
        checks++;
        if (s_adr !== 8'h10 || s_we !== 1'b1 || s_wdat !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_mux adr %h we %b dat %h exp 10 1 deadbeef", s_adr, s_we, s_wdat);
        end
        wait_ack(0, ok);
        checks++;
        if (!ok || m_ack !== 2'b01) begin
            errors++; $display("FAIL single_ack got %b exp 01", m_ack);
        end
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL single_release grant %b exp 00", grant);
        end
        m_we[0]  = 1'b0;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        wait_ack(0, ok);
        checks++;
        if (!ok || m_rdat[0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_read got %h exp deadbeef", m_rdat[0]);
        end
        checks++;
        if (m_rdat[1] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_broadcast got %h exp deadbeef", m_rdat[1]);
        end
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] seq [4];
        logic [1:0] exp_seq [4];
        logic [1:0] prev;
        int n;
        int direct;
        exp_seq[0] = 2'b01;
        exp_seq[1] = 2'b10;
        exp_seq[2] = 2'b01;
        exp_seq[3] = 2'b10;
        for (int i = 0; i < 4; i++) seq[i] = 2'bxx;
        @(negedge clk);
        rst = 1'b1;
        idle_all();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_adr[1] = 8'h10;
        m_cyc = 2'b11;
        m_stb = 2'b11;
        prev = 2'b00;
        n = 0;
        direct = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            #1;
            if (grant != 2'b00 && prev == 2'b00) begin
                seq[n] = grant;
                n++;
            end
            if (grant != 2'b00 && prev != 2'b00 && grant != prev) direct++;
            prev = grant;
            for (int m = 0; m < 2; m++) begin
                if (m_ack[m]) begin
                    m_cyc[m] = 1'b0;
                    m_stb[m] = 1'b0;
                end else if (!m_cyc[m]) begin
                    m_cyc[m] = 1'b1;
                    m_stb[m] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seq[i] !== exp_seq[i]) begin
                errors++; $display("FAIL rr_order[%0d] got %b exp %b", i, seq[i], exp_seq[i]);
            end
        end
        checks++;
        if (direct !== 0) begin
            errors++; $display("FAIL rr_dead_cycle direct handovers %0d exp 0", direct);
        end
        idle_all();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_burst();
        bit ok;
        bit m0_seen;
        bit lost;
        int acks;
        m0_seen = 1'b0;
        lost = 1'b0;
        acks = 0;
        ok = 1'b0;
        @(negedge clk);
        m_adr[1] = 8'h20;
        m_dat[1] = 32'h100;
        m_we[1]  = 1'b1;
        m_cti[1] = 3'b010;
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (grant == 2'b10) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL burst_grant got %b exp 10", grant);
        end
        m_adr[0] = 8'h21;
        m_we[0]  = 1'b0;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            ok = 1'b0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                #1;
                if (m_ack[0]) m0_seen = 1'b1;
                if (grant != 2'b10) lost = 1'b1;
                if (m_ack[1]) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (ok) acks++;
            if (b < 3) begin
                m_adr[1] = 8'h20 + 8'(b + 1);
                m_dat[1] = 32'h100 + 32'(b + 1);
                m_cti[1] = (b == 2) ? 3'b111 : 3'b010;
            end else begin
                m_cyc[1] = 1'b0;
                m_stb[1] = 1'b0;
                m_cti[1] = 3'b000;
            end
        end
        checks++;
        if (acks !== 4) begin
            errors++; $display("FAIL burst_acks got %0d exp 4", acks);
        end
        checks++;
        if (m0_seen !== 1'b0 || lost !== 1'b0) begin
            errors++; $display("FAIL burst_hold m0_ack %b grant_lost %b exp 0 0", m0_seen, lost);
        end
        checks++;
        if (mem[8'h20] !== 32'h100 || mem[8'h23] !== 32'h103) begin
            errors++; $display("FAIL burst_data got %h %h exp 100 103", mem[8'h20], mem[8'h23]);
        end
        wait_ack(0, ok);
        checks++;
        if (!ok || grant !== 2'b01 || m_rdat[0] !== 32'h101) begin
            errors++; $display("FAIL burst_m0_after grant %b dat %h exp 01 101", grant, m_rdat[0]);
        end
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        @(negedge clk);
        m_adr[0] = 8'h30;
        m_dat[0] = 32'h5555AAAA;
        m_we[0]  = 1'b1;
        m_cti[0] = 3'b010;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        wait_ack(0, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rstmid_first_ack got %b exp 01", m_ack);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (grant !== 2'b00 || s_cyc !== 1'b0) begin
            errors++; $display("FAIL rstmid_drop grant %b s_cyc %b exp 00 0", grant, s_cyc);
        end
        checks++;
        if (m_ack !== 2'b00) begin
            errors++; $display("FAIL rstmid_ack got %b exp 00", m_ack);
        end
        rst = 1'b0;
        idle_all();
        @(negedge clk);
        m_cyc = 2'b11;
        m_stb = 2'b11;
        @(negedge clk);
        #1;
        checks++;
        if (grant !== 2'b01) begin
            errors++; $display("FAIL rstmid_pointer grant %b exp 01", grant);
        end
        idle_all();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [1:0] exp_err;
        logic       exp_stb;
        @(negedge clk);
        hang = 1'b1;
        m_adr[0] = 8'h40;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
`ifdef PERIPHERAL_MPRAM_ARB_TIMEOUT_EN
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            #1;
            exp_err = (k == 4) ? 2'b01 : 2'b00;
            exp_stb = (k <= 4);
            checks++;
            if (m_err !== exp_err) begin
                errors++; $display("FAIL tmo_err[%0d] got %b exp %b", k, m_err, exp_err);
            end
            checks++;
            if (s_stb !== exp_stb) begin
                errors++; $display("FAIL tmo_stb[%0d] got %b exp %b", k, s_stb, exp_stb);
            end
        end
        checks++;
        if (grant !== 2'b01) begin
            errors++; $display("FAIL tmo_hold grant %b exp 01", grant);
        end
`else
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            #1;
            exp_err = 2'b00;
            exp_stb = 1'b1;
            checks++;
            if (grant !== 2'b01 || m_err !== exp_err || s_stb !== exp_stb) begin
                errors++; $display("FAIL hang_hold[%0d] grant %b err %b stb %b exp 01 00 1", k, grant, m_err, s_stb);
            end
        end
`endif
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        hang = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (grant !== 2'b00 || s_stb !== 1'b0) begin
            errors++; $display("FAIL tmo_release grant %b stb %b exp 00 0", grant, s_stb);
        end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
